// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register-file port (2 read, 1 write) between two requesters.
// Optional WAIT-state timeout is enabled by defining RF_TIMEOUT_EN.
module regfile_arbiter #(
   parameter int DW      = 16,
   parameter int AW      = 5,
   parameter int TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req,
   input  logic [5:0]      ops,
   input  logic [2*AW-1:0] raddr1,
   input  logic [2*AW-1:0] raddr2,
   input  logic [2*AW-1:0] waddr,
   input  logic [2*DW-1:0] wdata,
   output logic [1:0]      gnt,
   output logic [1:0]      done,
   output logic [1:0]      err,
   output logic [DW-1:0]   rdata1,
   output logic [DW-1:0]   rdata2,
   output logic            rf_valid,
   output logic [2:0]      rf_ops,
   output logic [AW-1:0]   rf_raddr1,
   output logic [AW-1:0]   rf_raddr2,
   output logic [AW-1:0]   rf_waddr,
   output logic [DW-1:0]   rf_wdata,
   input  logic [DW-1:0]   rf_rdata1,
   input  logic [DW-1:0]   rf_rdata2,
   input  logic            rf_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_d;
   logic            lp, lp_d;
   logic            w, w_d, w_sel;
   logic [2:0]      cmd_ops, cmd_ops_d;
   logic [AW-1:0]   cmd_ra1, cmd_ra1_d;
   logic [AW-1:0]   cmd_ra2, cmd_ra2_d;
   logic [AW-1:0]   cmd_wa, cmd_wa_d;
   logic [DW-1:0]   cmd_wd, cmd_wd_d;
   logic [1:0]      gnt_d, done_d;
   logic [DW-1:0]   rdata1_d, rdata2_d;
   logic            rf_valid_d;
   logic [2:0]      rf_ops_d;

`ifdef RF_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]   cnt, cnt_d;
   logic            tmo, tmo_d;
   logic [1:0]      err_q, err_d;
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   assign rf_raddr1 = cmd_ra1;
   assign rf_raddr2 = cmd_ra2;
   assign rf_waddr  = cmd_wa;
   assign rf_wdata  = cmd_wd;

   always_comb begin
      // NOTE: every signal assigned below gets a default first so no path leaves it unassigned (no latch).
      state_d    = state;
      lp_d       = lp;
      w_d        = w;
      w_sel      = 1'b0;
      cmd_ops_d  = cmd_ops;
      cmd_ra1_d  = cmd_ra1;
      cmd_ra2_d  = cmd_ra2;
      cmd_wa_d   = cmd_wa;
      cmd_wd_d   = cmd_wd;
      gnt_d      = 2'b00;
      done_d     = 2'b00;
      rdata1_d   = rdata1;
      rdata2_d   = rdata2;
      rf_valid_d = 1'b0;
      rf_ops_d   = 3'b000;
`ifdef RF_TIMEOUT_EN
      cnt_d      = cnt;
      tmo_d      = tmo;
      err_d      = 2'b00;
`endif
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               // Contention goes to the requester that was not served last.
               w_sel      = (req == 2'b11) ? ~lp : req[1];
               w_d        = w_sel;
               cmd_ops_d  = w_sel ? ops[5:3]          : ops[2:0];
               cmd_ra1_d  = w_sel ? raddr1[2*AW-1:AW] : raddr1[AW-1:0];
               cmd_ra2_d  = w_sel ? raddr2[2*AW-1:AW] : raddr2[AW-1:0];
               cmd_wa_d   = w_sel ? waddr[2*AW-1:AW]  : waddr[AW-1:0];
               cmd_wd_d   = w_sel ? wdata[2*DW-1:DW]  : wdata[DW-1:0];
               gnt_d      = w_sel ? 2'b10 : 2'b01;
               rf_valid_d = 1'b1;
               rf_ops_d   = cmd_ops_d;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
`ifdef RF_TIMEOUT_EN
            cnt_d = '0;
            tmo_d = 1'b0;
`endif
            state_d = (cmd_ops == 3'b000) ? RESP : WAIT;
         end
         WAIT: begin
            if (rf_done) begin
               rdata1_d = rf_rdata1;
               rdata2_d = rf_rdata2;
               state_d  = RESP;
            end
`ifdef RF_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT - 1)) begin
               rdata1_d = '0;
               rdata2_d = '0;
               tmo_d    = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt + CW'(1);
            end
`endif
         end
         RESP: begin
            done_d  = w ? 2'b10 : 2'b01;
`ifdef RF_TIMEOUT_EN
            err_d   = tmo ? done_d : 2'b00;
`endif
            lp_d    = w;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lp       <= 1'b1;
         w        <= 1'b0;
         cmd_ops  <= 3'b000;
         cmd_ra1  <= '0;
         cmd_ra2  <= '0;
         cmd_wa   <= '0;
         cmd_wd   <= '0;
         gnt      <= 2'b00;
         done     <= 2'b00;
         rdata1   <= '0;
         rdata2   <= '0;
         rf_valid <= 1'b0;
         rf_ops   <= 3'b000;
      end else begin
         state    <= state_d;
         lp       <= lp_d;
         w        <= w_d;
         cmd_ops  <= cmd_ops_d;
         cmd_ra1  <= cmd_ra1_d;
         cmd_ra2  <= cmd_ra2_d;
         cmd_wa   <= cmd_wa_d;
         cmd_wd   <= cmd_wd_d;
         gnt      <= gnt_d;
         done     <= done_d;
         rdata1   <= rdata1_d;
         rdata2   <= rdata2_d;
         rf_valid <= rf_valid_d;
         rf_ops   <= rf_ops_d;
      end
   end

`ifdef RF_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         tmo   <= 1'b0;
         err_q <= 2'b00;
      end else begin
         cnt   <= cnt_d;
         tmo   <= tmo_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 2'b00;
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: table of single-requester commands plus
// hand-written arbitration, reset-abort and (with RF_TIMEOUT_EN) timeout sequences.
module tb_regfile_arbiter;

   localparam int DW = 16;
   localparam int AW = 5;

   logic            clk, rst;
   logic [1:0]      req;
   logic [5:0]      ops;
   logic [2*AW-1:0] raddr1, raddr2, waddr;
   logic [2*DW-1:0] wdata;
   logic [1:0]      gnt, done, err;
   logic [DW-1:0]   rdata1, rdata2;
   logic            rf_valid;
   logic [2:0]      rf_ops;
   logic [AW-1:0]   rf_raddr1, rf_raddr2, rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic [DW-1:0]   rf_rdata1, rf_rdata2;
   logic            rf_done;

   int checks = 0;
   int errors = 0;

   regfile_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst), .req(req), .ops(ops),
      .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr), .wdata(wdata),
      .gnt(gnt), .done(done), .err(err), .rdata1(rdata1), .rdata2(rdata2),
      .rf_valid(rf_valid), .rf_ops(rf_ops), .rf_raddr1(rf_raddr1),
      .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_done(rf_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  req;
      logic [2:0]  op;
      logic [4:0]  ra1, ra2, wa;
      logic [15:0] wd;
      logic [15:0] rf1, rf2;
      int          delay;
      logic [1:0]  exp_gnt;
      logic [15:0] exp_r1, exp_r2;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input int id, input logic [2:0] o, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] aw, input logic [15:0] d);
      ops[3*id +: 3]     = o;
      raddr1[AW*id +: AW] = a1;
      raddr2[AW*id +: AW] = a2;
      waddr[AW*id +: AW]  = aw;
      wdata[DW*id +: DW]  = d;
   endtask

   task automatic check_issue(input string nm, input logic [1:0] eg, input logic [2:0] o,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [4:0] aw, input logic [15:0] d);
      check({nm, ".gnt"}, 32'(gnt), 32'(eg));
      check({nm, ".rf_valid"}, 32'(rf_valid), 32'd1);
      check({nm, ".rf_ops"}, 32'(rf_ops), 32'(o));
      check({nm, ".rf_raddr1"}, 32'(rf_raddr1), 32'(a1));
      check({nm, ".rf_raddr2"}, 32'(rf_raddr2), 32'(a2));
      check({nm, ".rf_waddr"}, 32'(rf_waddr), 32'(aw));
      check({nm, ".rf_wdata"}, 32'(rf_wdata), 32'(d));
   endtask

   // Called at the negedge where gnt was observed; returns at the negedge showing done.
   task automatic finish_cmd(input string nm, input int id, input logic [2:0] o, input int delay,
                             input logic [15:0] r1, input logic [15:0] r2,
                             input logic [15:0] e1, input logic [15:0] e2);
      int n;
      @(negedge clk);
      check({nm, ".gnt_pulse"}, 32'(gnt), 32'd0);
      check({nm, ".rf_valid_pulse"}, 32'(rf_valid), 32'd0);
      check({nm, ".rf_ops_idle"}, 32'(rf_ops), 32'd0);
      if (o != 3'b000) begin
         for (int k = 0; k < delay; k++) begin
            check({nm, ".early_done"}, 32'(done), 32'd0);
            @(negedge clk);
         end
         rf_done   = 1'b1;
         rf_rdata1 = r1;
         rf_rdata2 = r2;
         @(negedge clk);
         rf_done   = 1'b0;
         rf_rdata1 = 16'hDEAD;
         rf_rdata2 = 16'hDEAD;
      end
      n = 0;
      while (done == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({nm, ".done_latency"}, 32'(n), 32'd1);
      check({nm, ".done"}, 32'(done), (id == 1) ? 32'd2 : 32'd1);
      check({nm, ".err"}, 32'(err), 32'd0);
      check({nm, ".rdata1"}, 32'(rdata1), 32'(e1));
      check({nm, ".rdata2"}, 32'(rdata2), 32'(e2));
      req[id] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; ops = '0; raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0;
      rf_rdata1 = '0; rf_rdata2 = '0; rf_done = 1'b0;

      vecs[0] = '{req:2'b01, op:3'b100, ra1:5'd5,  ra2:5'd0,  wa:5'd0,  wd:16'h0000,
                  rf1:16'hBEEF, rf2:16'h0000, delay:2, exp_gnt:2'b01, exp_r1:16'hBEEF, exp_r2:16'h0000};
      vecs[1] = '{req:2'b10, op:3'b001, ra1:5'd3,  ra2:5'd4,  wa:5'd7,  wd:16'h1234,
                  rf1:16'hAAAA, rf2:16'h5555, delay:0, exp_gnt:2'b10, exp_r1:16'hAAAA, exp_r2:16'h5555};
      vecs[2] = '{req:2'b01, op:3'b000, ra1:5'd1,  ra2:5'd2,  wa:5'd3,  wd:16'h00FF,
                  rf1:16'h9999, rf2:16'h9999, delay:0, exp_gnt:2'b01, exp_r1:16'hAAAA, exp_r2:16'h5555};
      vecs[3] = '{req:2'b10, op:3'b110, ra1:5'd31, ra2:5'd0,  wa:5'd0,  wd:16'h0000,
                  rf1:16'h0F0F, rf2:16'hF0F0, delay:5, exp_gnt:2'b10, exp_r1:16'h0F0F, exp_r2:16'hF0F0};
      vecs[4] = '{req:2'b01, op:3'b111, ra1:5'd10, ra2:5'd21, wa:5'd31, wd:16'hFFFF,
                  rf1:16'h1357, rf2:16'h2468, delay:1, exp_gnt:2'b01, exp_r1:16'h1357, exp_r2:16'h2468};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.gnt", 32'(gnt), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.err", 32'(err), 32'd0);
      check("reset.rf_valid", 32'(rf_valid), 32'd0);
      check("reset.rf_ops", 32'(rf_ops), 32'd0);
      check("reset.rdata1", 32'(rdata1), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single-requester table; the idle slice carries inverted values.
      for (int i = 0; i < 5; i++) begin
         int id;
         string nm;
         id = vecs[i].req[1] ? 1 : 0;
         nm = $sformatf("vec%0d", i);
         load(1 - id, ~vecs[i].op, ~vecs[i].ra1, ~vecs[i].ra2, ~vecs[i].wa, ~vecs[i].wd);
         load(id, vecs[i].op, vecs[i].ra1, vecs[i].ra2, vecs[i].wa, vecs[i].wd);
         req = vecs[i].req;
         @(negedge clk);
         check_issue(nm, vecs[i].exp_gnt, vecs[i].op, vecs[i].ra1, vecs[i].ra2, vecs[i].wa, vecs[i].wd);
         finish_cmd(nm, id, vecs[i].op, vecs[i].delay, vecs[i].rf1, vecs[i].rf2,
                    vecs[i].exp_r1, vecs[i].exp_r2);
         @(negedge clk);
         check({nm, ".done_pulse"}, 32'(done), 32'd0);
      end

      // Simultaneous requests after reset: 0 first, then 1.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst2.rdata1", 32'(rdata1), 32'd0);
      load(0, 3'b100, 5'd2, 5'd0, 5'd0, 16'h0000);
      load(1, 3'b100, 5'd9, 5'd0, 5'd0, 16'h0000);
      req = 2'b11;
      @(negedge clk);
      check_issue("rr1a", 2'b01, 3'b100, 5'd2, 5'd0, 5'd0, 16'h0000);
      finish_cmd("rr1a", 0, 3'b100, 1, 16'h1111, 16'h0001, 16'h1111, 16'h0001);
      @(negedge clk);
      check("rr1b.done_pulse", 32'(done), 32'd0);
      check_issue("rr1b", 2'b10, 3'b100, 5'd9, 5'd0, 5'd0, 16'h0000);
      finish_cmd("rr1b", 1, 3'b100, 3, 16'h2222, 16'h0002, 16'h2222, 16'h0002);
      @(negedge clk);
      check("rr1.idle_gnt", 32'(gnt), 32'd0);

      // Serve requester 0 alone, then contention must favour requester 1.
      load(0, 3'b000, 5'd4, 5'd0, 5'd0, 16'h0000);
      req = 2'b01;
      @(negedge clk);
      check_issue("solo0", 2'b01, 3'b000, 5'd4, 5'd0, 5'd0, 16'h0000);
      finish_cmd("solo0", 0, 3'b000, 0, 16'h0, 16'h0, 16'h2222, 16'h0002);
      @(negedge clk);
      load(0, 3'b010, 5'd0, 5'd12, 5'd0, 16'h0000);
      load(1, 3'b010, 5'd0, 5'd17, 5'd0, 16'h0000);
      req = 2'b11;
      @(negedge clk);
      check_issue("rr2a", 2'b10, 3'b010, 5'd0, 5'd17, 5'd0, 16'h0000);
      req[1] = 1'b0;  // dropped early; the command must still complete
      finish_cmd("rr2a", 1, 3'b010, 2, 16'h3333, 16'h0003, 16'h3333, 16'h0003);
      @(negedge clk);
      check_issue("rr2b", 2'b01, 3'b010, 5'd0, 5'd12, 5'd0, 16'h0000);
      finish_cmd("rr2b", 0, 3'b010, 0, 16'h4444, 16'h0004, 16'h4444, 16'h0004);
      @(negedge clk);

      // Reset during WAIT aborts; a later rf_done must be ignored.
      load(0, 3'b100, 5'd6, 5'd0, 5'd0, 16'h0000);
      req = 2'b01;
      @(negedge clk);
      check_issue("abort", 2'b01, 3'b100, 5'd6, 5'd0, 5'd0, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      rf_done = 1'b1;
      rf_rdata1 = 16'hFFFF;
      rf_rdata2 = 16'hFFFF;
      @(negedge clk);
      rf_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("abort.done", 32'(done), 32'd0);
         check("abort.err", 32'(err), 32'd0);
         check("abort.rdata1", 32'(rdata1), 32'd0);
         check("abort.rf_valid", 32'(rf_valid), 32'd0);
         check("abort.gnt", 32'(gnt), 32'd0);
         @(negedge clk);
      end

`ifdef RF_TIMEOUT_EN
      begin
         int n;
         load(0, 3'b100, 5'd8, 5'd0, 5'd0, 16'h0000);
         req = 2'b01;
         @(negedge clk);
         check_issue("tmo", 2'b01, 3'b100, 5'd8, 5'd0, 5'd0, 16'h0000);
         n = 0;
         while (done == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
         end
         check("tmo.latency", 32'(n), 32'd34);
         check("tmo.done", 32'(done), 32'd1);
         check("tmo.err", 32'(err), 32'd1);
         check("tmo.rdata1", 32'(rdata1), 32'd0);
         check("tmo.rdata2", 32'(rdata2), 32'd0);
         req = 2'b00;
         @(negedge clk);
         check("tmo.err_pulse", 32'(err), 32'd0);
      end
`endif

      // Recovery after the abort: lp is back at 1, requester 1 alone.
      load(1, 3'b001, 5'd0, 5'd0, 5'd20, 16'hCAFE);
      req = 2'b10;
      @(negedge clk);
      check_issue("recover", 2'b10, 3'b001, 5'd0, 5'd0, 5'd20, 16'hCAFE);
      finish_cmd("recover", 1, 3'b001, 0, 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
